io_device_fifo: RTL and testbench
=================================

IO_DEVICE_FIFO -- requirements
Module: io_device_fifo

Interface
REQ-001 Parameters SHALL be: DATA_W, default 32, bus/entry width; DEPTH, default 32, FIFO entries (power of 2, >=4); ADDR_W, default 9, index width; BASE, default 192, buffer window base offset; THRESH, default 1, occupancy that raises GPIO.
REQ-002 The block SHALL have one clock; reset is asynchronous and active-high.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 index  input  ADDR_W  bit ADDR_W-1 = CS; bits ADDR_W-2:0 = offset.
REQ-006 IOWrite  input  1  1 = bus writes the device; 0 = device drives Data.
REQ-007 Ack  input  1  DMA acknowledge, one word per cycle while high.
REQ-008 Data  inout  DATA_W  shared bus; high-Z unless the device is the read source.
REQ-009 ext_valid  input  1  external producer word valid.
REQ-010 ext_data  input  DATA_W  external producer word.
REQ-011 ext_ready  output  1  push accepted this cycle.
REQ-012 GPIO  output  1  DMA request / interrupt line.
REQ-013 count  output  $clog2(DEPTH)+1  current occupancy.

Function
REQ-014 Storage SHALL be a circular FIFO with head/tail pointers wrapping modulo DEPTH; count ranges 0..DEPTH.
REQ-015 Access decode SHALL be: Ack=1 means DMA cycle (Ack wins over CS); else CS=1 with offset in BASE..BASE+DEPTH-1 means buffer window; offset BASE+DEPTH means status register; any other offset is ignored.
REQ-016 DMA write (Ack=1, IOWrite=1) SHALL push Data at the rising edge; DMA read (Ack=1, IOWrite=0) SHALL pop the head, with the popped word on Data in the following cycle (1-cycle latency).
REQ-017 CPU window write SHALL push Data regardless of offset; CPU window read at offset BASE+k SHALL peek entry head+k without popping, returning 0 when k>=count, 1-cycle latency.
REQ-018 Status read SHALL return {zeros, overflow, underflow, full, empty, count}; status write with Data[1]=1 clears underflow and Data[2]=1 clears overflow.
REQ-019 Data SHALL be driven only in the cycle after a registered read access and with IOWrite still 0; otherwise high-Z.
REQ-020 ext_ready SHALL equal !full && !(bus push this cycle); the bus push wins over the external push.
REQ-021 A push and pop in the same cycle SHALL both occur; count is unchanged, and this is legal at full or at empty (empty: the pop returns the pushed word).
REQ-022 A push when full and not popping SHALL be dropped and set sticky overflow.
REQ-023 A pop when empty SHALL return 0 and set sticky underflow.
REQ-024 The GPIO FSM SHALL have states IDLE, REQ, XFER: IDLE->REQ when count>=THRESH; REQ->XFER on Ack=1; XFER->IDLE when count reaches 0 after a pop; XFER->REQ when Ack drops and count>=THRESH; XFER->IDLE when Ack drops and count<THRESH.
REQ-025 GPIO SHALL be registered and equal 1 in REQ and XFER, 0 in IDLE.

Reset
REQ-026 Asserting reset at any time SHALL immediately clear pointers, count, flags and read data, set FSM=IDLE, GPIO=0, release Data to Z, and leave the buffer contents undefined.
REQ-027 An in-flight DMA burst interrupted by reset SHALL NOT resume after reset release.

Verification
REQ-028 Reset, then 3 ext pushes (A,B,C) with THRESH=1 -> ext_ready=1, count=3, GPIO=1 from the cycle after the first push.
REQ-029 With A,B,C queued: Ack=1, IOWrite=0 for 3 cycles -> Data = A,B,C on cycles 2-4, count=0, GPIO=0, FSM=IDLE.
REQ-030 Fill to DEPTH=32, then one more ext_valid -> ext_ready=0, word dropped; a CPU push at full -> overflow=1, status read shows full=1, count=32.
REQ-031 Empty FIFO with Ack=1 read -> Data=0, underflow=1; status write 0x2 -> underflow=0.
REQ-032 count=2 (X,Y); CPU read at index 448+1 (CS=1, offset 193) -> Data=Y, count stays 2; offset 200 -> 0.
REQ-033 Reset pulse mid-burst (count=5, Ack=1) -> count=0, GPIO=0, Data=Z asynchronously; after release with Ack held, no pop occurs and underflow sets.

Source files
------------

// File: rtl/io_device_fifo.sv
// io_device_fifo
//   Circular FIFO between an external producer and a host bus. The host side
//   reaches the buffer through DMA (Ack) cycles, a CPU peek/push window and a
//   status register. GPIO requests DMA service once occupancy reaches THRESH.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset
//   index      bus address: MSB is chip select, remaining bits are the offset
//   IOWrite    1 = bus writes the device, 0 = device may drive Data
//   Ack        DMA acknowledge, one word per cycle while high
//   Data       shared bidirectional bus, high-Z unless returning read data
//   ext_valid  external producer word valid
//   ext_data   external producer word
//   ext_ready  external push accepted this cycle
//   GPIO       registered DMA request / interrupt line
//   count      current occupancy (0..DEPTH)
module io_device_fifo #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 32,
   parameter int ADDR_W = 9,
   parameter int BASE   = 192,
   parameter int THRESH = 1
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [ADDR_W-1:0]        index,
   input  logic                     IOWrite,
   input  logic                     Ack,
   inout  wire logic [DATA_W-1:0]   Data,
   input  logic                     ext_valid,
   input  logic [DATA_W-1:0]        ext_data,
   output logic                     ext_ready,
   output logic                     GPIO,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CW    = PTR_W + 1;
   localparam logic [31:0] WIN_LO = 32'(BASE);
   localparam logic [31:0] WIN_HI = 32'(BASE + DEPTH);

   typedef enum logic [1:0] {IDLE, REQ, XFER} state_t;

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
   logic [CW-1:0]     count_q, count_d;
   logic              unf_q, unf_d, ovf_q, ovf_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              rd_q, rd_d;
   state_t            state_q, state_d;
   logic              gpio_q;

   // Address decode: Ack takes priority over any CPU access.
   logic        cs;
   logic [31:0] off;
   logic        win_hit, stat_hit;
   logic        dma_rd, dma_wr, win_rd, win_wr, stat_rd, stat_wr;
   logic [PTR_W-1:0] win_k;

   assign cs       = index[ADDR_W-1];
   assign off      = 32'(index[ADDR_W-2:0]);
   assign win_hit  = cs && (off >= WIN_LO) && (off < WIN_HI);
   assign stat_hit = cs && (off == WIN_HI);
   assign win_k    = PTR_W'(off - WIN_LO);

   assign dma_rd  = Ack && !IOWrite;
   assign dma_wr  = Ack && IOWrite;
   assign win_rd  = !Ack && win_hit && !IOWrite;
   assign win_wr  = !Ack && win_hit && IOWrite;
   assign stat_rd = !Ack && stat_hit && !IOWrite;
   assign stat_wr = !Ack && stat_hit && IOWrite;

   logic              full, empty, bus_push, push_req, do_push, do_pop;
   logic [DATA_W-1:0] push_data, status;

   assign full      = (count_q == CW'(DEPTH));
   assign empty     = (count_q == '0);
   assign bus_push  = dma_wr || win_wr;
   // The bus owns the write port whenever it pushes; the producer waits.
   assign ext_ready = !full && !bus_push;
   assign push_req  = bus_push || (ext_valid && ext_ready);
   assign push_data = bus_push ? Data : ext_data;
   // A simultaneous pop frees the slot, so a push at full still lands.
   assign do_push   = push_req && (!full || dma_rd);
   // At empty, a pop is only real if the same-cycle push feeds it.
   assign do_pop    = dma_rd && (!empty || do_push);
   assign status    = DATA_W'({ovf_q, unf_q, full, empty, count_q});

   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      unf_d   = unf_q;
      ovf_d   = ovf_q;
      rdata_d = rdata_q;
      rd_d    = dma_rd || win_rd || stat_rd;

      if (do_push) tail_d = tail_q + PTR_W'(1);
      if (do_pop)  head_d = head_q + PTR_W'(1);
      if (do_push && !do_pop)      count_d = count_q + CW'(1);
      else if (do_pop && !do_push) count_d = count_q - CW'(1);

      if (stat_wr) begin
         if (Data[1]) unf_d = 1'b0;
         if (Data[2]) ovf_d = 1'b0;
      end
      if (dma_rd && empty && !push_req) unf_d = 1'b1;
      if (push_req && full && !dma_rd)  ovf_d = 1'b1;

      if (dma_rd) begin
         if (!empty)       rdata_d = mem_q[head_q];
         else if (do_push) rdata_d = push_data;
         else              rdata_d = '0;
      end else if (win_rd) begin
         if ({1'b0, win_k} < count_q) rdata_d = mem_q[head_q + win_k];
         else                         rdata_d = '0;
      end else if (stat_rd) begin
         rdata_d = status;
      end
   end

   // GPIO request FSM; transitions look at the post-update occupancy so the
   // request rises right after the push that crosses THRESH.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: if (count_d >= CW'(THRESH)) state_d = REQ;
         REQ:  if (Ack) state_d = XFER;
         XFER: begin
            if (dma_rd && (count_d == '0)) state_d = IDLE;
            else if (!Ack) state_d = (count_d >= CW'(THRESH)) ? REQ : IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         unf_q   <= 1'b0;
         ovf_q   <= 1'b0;
         rdata_q <= '0;
         rd_q    <= 1'b0;
         state_q <= IDLE;
         gpio_q  <= 1'b0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         unf_q   <= unf_d;
         ovf_q   <= ovf_d;
         rdata_q <= rdata_d;
         rd_q    <= rd_d;
         state_q <= state_d;
         gpio_q  <= (state_d != IDLE);
      end
   end

   // Buffer storage is not reset.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[tail_q] <= push_data;
   end

   // Drive only while the host is still reading in the cycle after the access.
   assign Data  = (rd_q && !IOWrite) ? rdata_q : {DATA_W{1'bz}};
   assign GPIO  = gpio_q;
   assign count = count_q;

endmodule

// File: tb/tb_io_device_fifo.sv
module tb_io_device_fifo;
   localparam int DW     = 32;
   localparam int DEPTH  = 32;
   localparam int AW     = 9;
   localparam int BASE   = 192;
   localparam int THRESH = 1;
   localparam logic [AW-1:0] STAT_IDX = AW'(256 + BASE + DEPTH);

   logic          clk = 1'b0;
   logic          reset;
   logic [AW-1:0] index;
   logic          IOWrite, Ack, ext_valid;
   logic [DW-1:0] ext_data, tb_data;
   wire  [DW-1:0] Data;
   logic          ext_ready, GPIO;
   logic [5:0]    count;

   assign Data = IOWrite ? tb_data : {DW{1'bz}};

   io_device_fifo #(.DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW), .BASE(BASE), .THRESH(THRESH)) dut (
      .clk(clk), .reset(reset), .index(index), .IOWrite(IOWrite), .Ack(Ack),
      .Data(Data), .ext_valid(ext_valid), .ext_data(ext_data),
      .ext_ready(ext_ready), .GPIO(GPIO), .count(count)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int errs    = 0;

   // Reference model: word queue, sticky flags, request phase, pending read.
   logic [31:0] q[$];
   bit          m_unf, m_ovf;
   int          m_st;          // 0 idle, 1 requesting, 2 transferring
   bit          m_rdv;
   logic [31:0] m_rd;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      q.delete();
      m_unf = 0; m_ovf = 0; m_st = 0; m_rdv = 0; m_rd = '0;
   endtask

   task automatic model_edge(output bit rdy);
      int n, off, k;
      bit full, cs, win, stat, pop, bpush, preq;
      logic [31:0] pw, s;
      n     = q.size();
      full  = (n == DEPTH);
      cs    = index[AW-1];
      off   = int'(index[AW-2:0]);
      win   = cs && off >= BASE && off < BASE + DEPTH;
      stat  = cs && off == BASE + DEPTH;
      pop   = Ack && !IOWrite;
      bpush = (Ack && IOWrite) || (!Ack && win && IOWrite);
      rdy   = !full && !bpush;
      preq  = bpush || (ext_valid && rdy);
      pw    = bpush ? tb_data : ext_data;
      m_rdv = 0;
      if (!Ack && stat && IOWrite) begin
         if (tb_data[1]) m_unf = 0;
         if (tb_data[2]) m_ovf = 0;
      end
      if (pop) begin
         m_rdv = 1;
         if (n > 0) m_rd = q.pop_front();
         else if (preq) begin m_rd = pw; preq = 0; end
         else begin m_rd = '0; m_unf = 1; end
      end else if (!Ack && win && !IOWrite) begin
         k = off - BASE;
         m_rd  = (k < n) ? q[k] : '0;
         m_rdv = 1;
      end else if (!Ack && stat && !IOWrite) begin
         s = '0;
         s[5:0] = 6'(n);
         s[6] = (n == 0);
         s[7] = full;
         s[8] = m_unf;
         s[9] = m_ovf;
         m_rd  = s;
         m_rdv = 1;
      end
      if (preq) begin
         if (q.size() < DEPTH) q.push_back(pw);
         else m_ovf = 1;
      end
      n = q.size();
      case (m_st)
         0: if (n >= THRESH) m_st = 1;
         1: if (Ack) m_st = 2;
         default: begin
            if (pop && n == 0) m_st = 0;
            else if (!Ack) m_st = (n >= THRESH) ? 1 : 0;
         end
      endcase
   endtask

   // One clock: apply inputs, check ready, advance model, check outputs.
   task automatic cyc(input bit ack, input bit iow, input logic [AW-1:0] idx,
                      input logic [31:0] d, input bit ev, input logic [31:0] ed);
      bit rdy;
      Ack = ack; IOWrite = iow; index = idx; tb_data = d;
      ext_valid = ev; ext_data = ed;
      #1;
      model_edge(rdy);
      chk("ext_ready", 32'(ext_ready), 32'(rdy));
      @(posedge clk); #1;
      chk("count", 32'(count), 32'(q.size()));
      chk("gpio", 32'(GPIO), 32'(m_st != 0));
      if (m_rdv) chk("data", Data, m_rd);
   endtask

   task automatic idle();
      cyc(0, 0, '0, '0, 0, '0);
   endtask

   initial begin
      logic [31:0] w;
      int r;
      Ack = 0; IOWrite = 0; index = '0; tb_data = '0; ext_valid = 0; ext_data = '0;
      reset = 1;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_gpio", 32'(GPIO), 32'd0);
      chk("rst_ready", 32'(ext_ready), 32'd1);
      reset = 0;

      // Three producer words raise the request line.
      cyc(0, 0, '0, '0, 1, 32'hAAAA_0001);
      chk("gpio_first_push", 32'(GPIO), 32'd1);
      cyc(0, 0, '0, '0, 1, 32'hBBBB_0002);
      cyc(0, 0, '0, '0, 1, 32'hCCCC_0003);
      chk("count3", 32'(count), 32'd3);

      // DMA burst drains them in order.
      cyc(1, 0, '0, '0, 0, '0);
      chk("dma_A", Data, 32'hAAAA_0001);
      cyc(1, 0, '0, '0, 0, '0);
      chk("dma_B", Data, 32'hBBBB_0002);
      cyc(1, 0, '0, '0, 0, '0);
      chk("dma_C", Data, 32'hCCCC_0003);
      chk("drained_gpio", 32'(GPIO), 32'd0);
      idle();

      // Fill to full, then try the producer and a CPU window push.
      for (int i = 0; i < DEPTH; i++) cyc(0, 0, '0, '0, 1, $urandom);
      Ack = 0; IOWrite = 0; ext_valid = 1; #1;
      chk("ready_at_full", 32'(ext_ready), 32'd0);
      cyc(0, 0, '0, '0, 1, 32'hDEAD_BEEF);
      cyc(0, 1, AW'(256 + BASE + 3), 32'h1234_5678, 0, '0);
      cyc(0, 0, STAT_IDX, '0, 0, '0);
      chk("status_full_ovf", Data, 32'h0000_02A0);

      // Drain, then underflow and clear it.
      for (int i = 0; i < DEPTH; i++) cyc(1, 0, '0, '0, 0, '0);
      idle();
      cyc(1, 0, '0, '0, 0, '0);
      chk("underflow_data", Data, 32'd0);
      cyc(0, 0, STAT_IDX, '0, 0, '0);
      chk("status_unf_ovf", Data, 32'h0000_0340);
      cyc(0, 1, STAT_IDX, 32'h2, 0, '0);
      cyc(0, 0, STAT_IDX, '0, 0, '0);
      chk("status_unf_clr", Data, 32'h0000_0240);
      cyc(0, 1, STAT_IDX, 32'h4, 0, '0);

      // CPU peek window.
      cyc(0, 0, '0, '0, 1, 32'h0000_00F0);
      cyc(0, 0, '0, '0, 1, 32'h0000_00F1);
      cyc(0, 0, AW'(448 + 1), '0, 0, '0);
      chk("peek_Y", Data, 32'h0000_00F1);
      chk("peek_count", 32'(count), 32'd2);
      cyc(0, 0, AW'(256 + 200), '0, 0, '0);
      chk("peek_beyond", Data, 32'd0);

      // Push and pop together at empty: the pop returns the pushed word.
      cyc(1, 0, '0, '0, 0, '0);
      cyc(1, 0, '0, '0, 0, '0);
      cyc(1, 0, '0, '0, 1, 32'h5A5A_A5A5);
      chk("bypass_data", Data, 32'h5A5A_A5A5);
      chk("bypass_count", 32'(count), 32'd0);
      idle();
      cyc(0, 0, STAT_IDX, '0, 0, '0);
      chk("bypass_status", Data, 32'h0000_0040);

      // Randomized traffic against the model.
      for (int i = 0; i < 600; i++) begin
         r = $urandom_range(0, 9);
         w = $urandom;
         case (r)
            0, 1, 2: cyc(0, 0, '0, '0, 1, w);
            3, 4:    cyc(1, 0, AW'($urandom), '0, $urandom_range(0, 1) == 1, w);
            5:       cyc(1, 1, AW'($urandom), w, $urandom_range(0, 1) == 1, ~w);
            6:       cyc(0, 1, AW'(256 + BASE + $urandom_range(0, DEPTH - 1)), w, 1, ~w);
            7:       cyc(0, 0, AW'(256 + BASE + $urandom_range(0, DEPTH + 1)), '0,
                         $urandom_range(0, 1) == 1, w);
            8:       if (w[0]) cyc(0, 1, STAT_IDX, w & 32'h6, 0, '0);
                     else      cyc(0, 0, STAT_IDX, '0, 0, '0);
            default: cyc(0, w[0], AW'($urandom_range(0, 191)), w, 1, ~w);
         endcase
      end

      // Reset in the middle of a burst.
      reset = 1; #1; reset = 0;
      model_reset();
      idle();
      for (int i = 0; i < 5; i++) cyc(0, 0, '0, '0, 1, 32'h100 + 32'(i));
      cyc(1, 0, '0, '0, 0, '0);
      reset = 1;
      #2;
      chk("async_rst_count", 32'(count), 32'd0);
      chk("async_rst_gpio", 32'(GPIO), 32'd0);
      model_reset();
      @(posedge clk); #1;
      reset = 0;
      cyc(1, 0, '0, '0, 0, '0);
      chk("post_rst_pop", Data, 32'd0);
      chk("post_rst_count", 32'(count), 32'd0);
      idle();
      cyc(0, 0, STAT_IDX, '0, 0, '0);
      chk("post_rst_status", Data, 32'h0000_0140);
      idle();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end
endmodule
